pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width, held through bubbles, range 1..256.
REQ-002 SHALL have parameter CTRL_W, default 12: control width (reg_write, mem_read, mem_write, wb_sel, ...), forced to 0 on bubbles, range 1..64.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: upstream holds a valid entry.
REQ-006 SHALL have port in_ready  output  1: stage can accept an entry this cycle.
REQ-007 SHALL have port in_data  input  DATA_W: upstream payload.
REQ-008 SHALL have port in_ctrl  input  CTRL_W: upstream control bits.
REQ-009 SHALL have port flush  input  1: discard all held entries.
REQ-010 SHALL have port out_valid  output  1: downstream entry valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  DATA_W: downstream payload.
REQ-013 SHALL have port out_ctrl  output  CTRL_W: downstream control bits.
REQ-014 SHALL have port stall_cnt  output  32: count of backpressure cycles.

Function
REQ-015 SHALL hold two entries: main (drives out_*) and skid (overflow), each with its own valid bit.
REQ-016 SHALL drive in_ready directly from a register (= NOT skid_valid), with no combinational path from out_ready.
REQ-017 SHALL accept an entry on a rising edge with in_valid=1 and in_ready=1, and SHALL complete a transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-018 SHALL load an accepted entry into main when main is empty or is transferring and skid is empty, otherwise into skid.
REQ-019 SHALL move skid into main on a transfer while skid is valid; the accepted entry then lands in skid (skid_valid remains 1).
REQ-020 SHALL give 1-cycle latency in_valid->out_valid when empty and sustain 1 entry/cycle with out_ready held high.
REQ-021 SHALL preserve order: no entry dropped or duplicated except by flush or rst.
REQ-022 SHALL drive out_ctrl=0 whenever out_valid=0; out_data keeps its last value during bubbles.
REQ-023 SHALL on flush=1 clear both valid bits at the next edge and ignore any same-cycle accept; flush takes priority over accept and transfer.
REQ-024 SHALL set in_ready=1 in the cycle after a flush.
REQ-025 SHALL leave state unchanged when in_valid=0 and out_ready=0.

Reset
REQ-026 SHALL on rst=1 at an edge clear main_valid, skid_valid, main/skid data, main/skid ctrl and stall_cnt to 0; rst has priority over flush and all handshakes.
REQ-027 SHALL hold in_ready=0 while rst is high and set in_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL, when rst is applied mid-operation, discard held entries with out_valid=0 and out_ctrl=0 from the next cycle.

Configuration
REQ-029 SHALL, when PIPE_SKID_STALL_CNT_EN is defined, increment stall_cnt by 1 each cycle with out_valid=1 and out_ready=0, wrapping 0xFFFFFFFF->0, unaffected by flush and cleared only by rst.
REQ-030 SHALL, when PIPE_SKID_STALL_CNT_EN is undefined, tie stall_cnt to 0 and synthesise no counter logic.

Verification
REQ-031 SHALL verify single entry: in_data=0x1234, in_ctrl=0x005, out_ready=1 -> out_valid=1 and out_data=0x1234 one cycle later, then out_ctrl=0 on the bubble.
REQ-032 SHALL verify streaming: 8 entries 0..7 with out_ready=1 -> out_data 0..7 on consecutive cycles, in_ready constantly 1.
REQ-033 SHALL verify backpressure: send 0xA then 0xB, out_ready=0 for 3 cycles -> in_ready=0 after 0xB lands in skid; release -> 0xA then 0xB, stall_cnt=3 (macro on) or 0 (macro off).
REQ-034 SHALL verify flush: both entries held, flush with in_valid=1 (in_data=0xC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, 0xC never appears.
REQ-035 SHALL verify mid-operation reset: rst during a stall with skid full -> out_valid=0 and stall_cnt=0 next cycle, in_ready=1 the cycle after rst drops.
REQ-036 SHALL verify random valid/ready at DATA_W=64, CTRL_W=4 for 10k cycles -> scoreboard shows in-order, lossless delivery with no combinational in_ready dependency on out_ready.

Source files
------------

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream (in_*) and downstream (out_*)
// valid/ready channels. The stage connects through the slave modport; whoever
// drives and consumes the stage (producer plus consumer) uses master.
interface pipe_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register. The main entry drives the
// downstream side; the skid entry absorbs the one entry accepted while
// downstream stalls, so in_ready can be a pure register (no path from
// out_ready). Control bits are zeroed on bubbles; payload is held.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to enable the stall counter.
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_skid_stage_if.slave      bus,
  input  logic                  flush,
  output logic [31:0]           stall_cnt
);

  logic              main_valid, main_valid_n;
  logic              skid_valid, skid_valid_n;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
  logic              accept;
  logic              xfer;

  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = main_valid & bus.out_ready;

  // Next-state for both entries from the accept/transfer handshakes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_data_n  = main_data;
    skid_data_n  = skid_data;
    main_ctrl_n  = main_ctrl;
    skid_ctrl_n  = skid_ctrl;

    if (xfer && skid_valid) begin
      // Skid drains into main; anything accepted now refills skid.
      main_valid_n = 1'b1;
      main_data_n  = skid_data;
      main_ctrl_n  = skid_ctrl;
      skid_valid_n = accept;
      if (accept) begin
        skid_data_n = bus.in_data;
        skid_ctrl_n = bus.in_ctrl;
      end
    end else if (!main_valid || xfer) begin
      // Main is free this cycle: the accepted entry goes straight to it.
      main_valid_n = accept;
      if (accept) begin
        main_data_n = bus.in_data;
        main_ctrl_n = bus.in_ctrl;
      end
    end else if (accept) begin
      // Main is stalled: overflow into skid.
      skid_valid_n = 1'b1;
      skid_data_n  = bus.in_data;
      skid_ctrl_n  = bus.in_ctrl;
    end

    // Empty entries carry no control so out_ctrl reads 0 on bubbles.
    if (!main_valid_n) main_ctrl_n = '0;
    if (!skid_valid_n) skid_ctrl_n = '0;
  end

  // Entry registers; reset beats flush, flush beats the handshakes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: payload registers are reset too; they are plain flops, not a
      // RAM, and a clean out_data after reset is part of the contract.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      main_ctrl  <= main_ctrl_n;
      skid_ctrl  <= skid_ctrl_n;
      in_ready_q <= ~skid_valid_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count cycles where downstream holds off a valid entry; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !bus.out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage (DATA_W=64, CTRL_W=4): directed
// vector table, hand-written flush/reset sequences and a random
// valid/ready run against a FIFO scoreboard.
module tb_pipe_skid_stage;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;
`ifdef PIPE_SKID_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] stall_cnt;

  pipe_skid_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [3:0] c,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  typedef struct {
    logic        in_valid;
    logic [63:0] in_data;
    logic [3:0]  in_ctrl;
    logic        out_ready;
    logic        flush;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [3:0]  exp_ctrl;
    logic        exp_in_ready;
    logic [31:0] exp_stall;   // value with the counter enabled
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic [3:0] c,
                              input logic ordy, input logic fl, input logic ev,
                              input logic [63:0] ed, input logic [3:0] ec,
                              input logic eir, input logic [31:0] es);
    vec_t t;
    t.in_valid = v;   t.in_data = d;   t.in_ctrl = c;  t.out_ready = ordy; t.flush = fl;
    t.exp_valid = ev; t.exp_data = ed; t.exp_ctrl = ec; t.exp_in_ready = eir;
    t.exp_stall = es;
    return t;
  endfunction

  vec_t        vecs[$];
  logic [67:0] sb[$];     // {ctrl, data} in acceptance order

  initial begin
    // ---- vector table: inputs before an edge, outputs just after it ----
    // single entry then bubble
    vecs.push_back(mk(1, 64'h1234, 4'h5, 1, 0,  1, 64'h1234, 4'h5, 1, 0));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  0, 64'h1234, 4'h0, 1, 0));
    // streaming 0..7 at one entry per cycle
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 64'(i), 4'(i + 1), 1, 0, 1, 64'(i), 4'(i + 1), 1, 0));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  0, 64'h7,    4'h0, 1, 0));
    // backpressure: A to main, B to skid, 3 stalled cycles, release
    vecs.push_back(mk(1, 64'hA,    4'h1, 0, 0,  1, 64'hA,    4'h1, 1, 0));
    vecs.push_back(mk(1, 64'hB,    4'h2, 0, 0,  1, 64'hA,    4'h1, 0, 1));
    vecs.push_back(mk(0, 64'h0,    4'h0, 0, 0,  1, 64'hA,    4'h1, 0, 2));
    vecs.push_back(mk(0, 64'h0,    4'h0, 0, 0,  1, 64'hA,    4'h1, 0, 3));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  1, 64'hB,    4'h2, 1, 3));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  0, 64'hB,    4'h0, 1, 3));
    // flush with both entries held and in_valid=1 (0xC must never appear)
    vecs.push_back(mk(1, 64'h11,   4'h3, 0, 0,  1, 64'h11,   4'h3, 1, 3));
    vecs.push_back(mk(1, 64'h22,   4'h4, 0, 0,  1, 64'h11,   4'h3, 0, 4));
    vecs.push_back(mk(1, 64'hC,    4'h5, 0, 1,  0, 64'h11,   4'h0, 1, 5));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  0, 64'h11,   4'h0, 1, 5));
    // flush wins over a same-cycle accept and transfer
    vecs.push_back(mk(1, 64'h33,   4'h6, 0, 0,  1, 64'h33,   4'h6, 1, 5));
    vecs.push_back(mk(1, 64'hD,    4'h7, 1, 1,  0, 64'h33,   4'h0, 1, 5));
    vecs.push_back(mk(0, 64'h0,    4'h0, 1, 0,  0, 64'h33,   4'h0, 1, 5));

    // ---- reset ----
    rst = 1'b1;
    drive(0, 64'h0, 4'h0, 0, 0);
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_data",  bus.out_data,       64'd0);
    check("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("rst_stall_cnt", 64'(stall_cnt),     64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_ctrl,
            vecs[i].out_ready, vecs[i].flush);
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_out_data",  i), bus.out_data,       vecs[i].exp_data);
      check($sformatf("vec%0d_out_ctrl",  i), 64'(bus.out_ctrl),  64'(vecs[i].exp_ctrl));
      check($sformatf("vec%0d_in_ready",  i), 64'(bus.in_ready),  64'(vecs[i].exp_in_ready));
      check($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt),
            STALL_EN ? 64'(vecs[i].exp_stall) : 64'd0);
    end

    // ---- mid-operation reset with skid full ----
    drive(1, 64'h44, 4'h1, 0, 0); tick();
    drive(1, 64'h55, 4'h2, 0, 0); tick();
    check("mr_skid_full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(0, 64'h0, 4'h0, 0, 0);  tick();
    check("mr_held_out_data", bus.out_data, 64'h44);
    rst = 1'b1;
    drive(1, 64'h66, 4'h3, 1, 0);
    tick();
    check("mr_out_valid", 64'(bus.out_valid), 64'd0);
    check("mr_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("mr_out_data",  bus.out_data,       64'd0);
    check("mr_stall_cnt", 64'(stall_cnt),     64'd0);
    check("mr_in_ready_in_rst", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    drive(0, 64'h0, 4'h0, 1, 0);
    tick();
    check("mr_in_ready_after", 64'(bus.in_ready),  64'd1);
    check("mr_out_valid_after", 64'(bus.out_valid), 64'd0);
    drive(1, 64'h77, 4'h9, 1, 0); tick();
    check("mr_latency_valid", 64'(bus.out_valid), 64'd1);
    check("mr_latency_data",  bus.out_data,       64'h77);
    drive(0, 64'h0, 4'h0, 1, 0);  tick();
    check("mr_drained", 64'(bus.out_valid), 64'd0);

    // ---- random valid/ready, scoreboard ----
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic ir;
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
            1'($urandom_range(0, 1)), 0);
      if (cyc % 50 == 0) begin
        ir = bus.in_ready;
        bus.out_ready = ~bus.out_ready;
        #1;
        check("rnd_in_ready_indep", 64'(bus.in_ready), 64'(ir));
        bus.out_ready = ~bus.out_ready;
        #1;
      end
      if (!bus.out_valid)
        check("rnd_bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_out", 64'd1, 64'd0);
        end else begin
          logic [67:0] e;
          e = sb.pop_front();
          check("rnd_data", bus.out_data,      e[63:0]);
          check("rnd_ctrl", 64'(bus.out_ctrl), 64'(e[67:64]));
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back({bus.in_ctrl, bus.in_data});
      tick();
    end

    // drain with a bounded budget
    drive(0, 64'h0, 4'h0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("drain_unexpected_out", 64'd1, 64'd0);
        end else begin
          logic [67:0] e;
          e = sb.pop_front();
          check("drain_data", bus.out_data,      e[63:0]);
          check("drain_ctrl", 64'(bus.out_ctrl), 64'(e[67:64]));
        end
      end
      tick();
    end
    check("sb_empty",       64'(sb.size()),      64'd0);
    check("final_in_ready", 64'(bus.in_ready),   64'd1);
    check("final_idle",     64'(bus.out_valid),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
